// File: rtl/tv_sequencer_checker_pkg.sv
// Shared types and constants for the truth-table sequencer/checker.
package tv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_NUM_IN        = 3;
  localparam int NUM_VEC           = 2 ** DEF_NUM_IN;
  localparam int DEF_SETTLE_CYCLES = 5;
  localparam logic [NUM_VEC-1:0] DEF_EXP_TABLE = 8'h10;

  // Ceiling log2, floored at 1 so a one-cycle settle still gets a real counter bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((2 ** w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tv_settle_timer.sv
// Loadable down-counter; holds at zero and flags it.
module tv_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tv_sequencer_checker.sv
// Walks every input vector of a small combinational DUT and checks F against a table.
// Optional build macro STOP_ON_FAIL_EN: end the run at the first mismatching vector.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | vec_out applied, counting down the settle window
// CHECK  | sample dut_f, score it, advance or finish
// DONE   | results held until the next start
module tv_sequencer_checker
  import tv_pkg::*;
#(
  parameter int NUM_IN        = DEF_NUM_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic [2**NUM_IN-1:0] EXP_TABLE = DEF_EXP_TABLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dut_f,
  output logic [NUM_IN-1:0] vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   fail_count,
  output logic              first_fail_valid,
  output logic [NUM_IN-1:0] first_fail_vec
);

  localparam int CW       = clog2(SETTLE_CYCLES);
  localparam int VEC_LAST = 2 ** NUM_IN - 1;
`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t state;
  logic   timer_load;
  logic   timer_zero;
  logic   mismatch;
  logic   last_vec;
  logic   finish_run;
  logic   launch;

  always_comb begin
    launch     = ((state == IDLE) || (state == DONE)) && start;
    mismatch   = (dut_f != EXP_TABLE[vec_out]);
    last_vec   = (vec_out == NUM_IN'(VEC_LAST));
    finish_run = last_vec || (STOP_ON_FAIL && mismatch);
    timer_load = launch || ((state == CHECK) && !finish_run);
  end

  tv_settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (state == SETTLE),
    .load_val (CW'(SETTLE_CYCLES - 1)),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_out          <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            done             <= 1'b0;
            busy             <= 1'b1;
            state            <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_zero) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            fail_count <= fail_count + (NUM_IN+1)'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec_out;
            end
          end
          if (finish_run) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            vec_out <= vec_out + NUM_IN'(1);
            state   <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // fail_count only moves while busy, so this is stable whenever done is high.
  assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_tv_sequencer_checker.sv
// Scoreboard bench for tv_sequencer_checker with a switchable ideal/stuck-at DUT model.
module tb_tv_sequencer_checker;

  localparam logic [7:0] EXP = 8'h10;
  localparam int MODE_IDEAL = 0;
  localparam int MODE_SA0   = 1;
  localparam int MODE_SA1   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dut_f;
  logic [2:0] vec_out;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic       first_fail_valid;
  logic [2:0] first_fail_vec;

  int mode = MODE_IDEAL;
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_tab;

  typedef struct {
    int fc;
    bit ffv;
    int ffvec;
    bit pass;
    int lat;
    int last_vec;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign dut_f = (mode == MODE_IDEAL) ? exp_tab[vec_out] :
                 (mode == MODE_SA0)   ? 1'b0 : 1'b1;

  tv_sequencer_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dut_f            (dut_f),
    .vec_out          (vec_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  function automatic exp_t model(input int m);
    exp_t e;
    logic f;
    logic [7:0] t;
    t = EXP;
    e = '{fc: 0, ffv: 0, ffvec: 0, pass: 0, lat: 0, last_vec: 0};
    for (int v = 0; v < 8; v++) begin
      f = (m == MODE_IDEAL) ? t[v] : (m == MODE_SA0) ? 1'b0 : 1'b1;
      e.lat += 6;
      e.last_vec = v;
      if (f != t[v]) begin
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffvec = v;
        end
        e.fc++;
`ifdef STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    e.pass = (e.fc == 0);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({vec_out, busy, done, pass, fail_count, first_fail_valid, first_fail_vec} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got vec=%0d busy=%0b done=%0b pass=%0b fc=%0d ffv=%0b ffvec=%0d, expected all 0",
               vec_out, busy, done, pass, fail_count, first_fail_valid, first_fail_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  // Starts one run, optionally pulses start while busy, then scores the result against the queue.
  task automatic run_vectors(input int m, input bit hammer, input string name);
    exp_t e;
    int cycles;
    mode = m;
    exp_q.push_back(model(m));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0 || fail_count !== 4'd0 || first_fail_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_launch: got busy=%0b done=%0b fc=%0d ffv=%0b, expected 1 0 0 0",
               name, busy, done, fail_count, first_fail_valid);
    end
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (hammer) start = (cycles % 7 == 3) && (cycles < 40);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (cycles !== e.lat) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cycles, e.lat);
    end
    tests_run++;
    if (fail_count !== 4'(e.fc)) begin
      tests_failed++;
      $display("FAIL %s_fail_count: got %0d, expected %0d", name, fail_count, e.fc);
    end
    tests_run++;
    if (first_fail_valid !== e.ffv || (e.ffv && first_fail_vec !== 3'(e.ffvec))) begin
      tests_failed++;
      $display("FAIL %s_first_fail: got valid=%0b vec=%0d, expected valid=%0b vec=%0d",
               name, first_fail_valid, first_fail_vec, e.ffv, e.ffvec);
    end
    tests_run++;
    if (pass !== e.pass || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_pass_busy: got pass=%0b busy=%0b, expected pass=%0b busy=0",
               name, pass, busy, e.pass);
    end
    tests_run++;
    if (vec_out !== 3'(e.last_vec)) begin
      tests_failed++;
      $display("FAIL %s_final_vec: got %0d, expected %0d", name, vec_out, e.last_vec);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_done_hold: got done=%0b busy=%0b, expected 1 0", name, done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    mode = MODE_IDEAL;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (vec_out !== 3'd3 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_position: got vec=%0d busy=%0b, expected 3 1", vec_out, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({vec_out, busy, done, pass, fail_count, first_fail_valid, first_fail_vec} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got vec=%0d busy=%0b done=%0b fc=%0d, expected all 0",
               vec_out, busy, done, fail_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 3'd0) begin
      tests_failed++;
      $display("FAIL idle_after_midrun_reset: got busy=%0b done=%0b vec=%0d, expected 0 0 0",
               busy, done, vec_out);
    end
  endtask

  initial begin
    exp_tab = EXP;
    test_reset();
    run_vectors(MODE_IDEAL, 1'b0, "ideal");
    run_vectors(MODE_SA0, 1'b0, "stuck0");
    run_vectors(MODE_SA1, 1'b0, "stuck1");
    run_vectors(MODE_IDEAL, 1'b1, "busy_start");
    run_vectors(MODE_SA1, 1'b0, "restart_from_done");
    test_reset_mid_run();
    run_vectors(MODE_IDEAL, 1'b0, "after_reset");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
